// File: rtl/edge_evt_pkg.sv
// Shared types for the edge-event arbiter: edge polarity and arbiter state.
package edge_evt_pkg;

    // Polarity of a delivered event, matching the evt_fall_o encoding.
    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_e;

    // IDLE: nothing presented. HOLD: an event is presented on the stream.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/edge_evt_chan.sv
// One monitored line: edge detection, rise/fall pending bits, sticky
// overflow, and the choice of which pending edge is older.
module edge_evt_chan
    import edge_evt_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic armed_i,
    input  logic d_i,
    input  logic en_i,
    input  logic rise_en_i,
    input  logic fall_en_i,
    input  logic grant_rise_i,
    input  logic grant_fall_i,
    output logic rise_pend_o,
    output logic fall_pend_o,
    output logic overflow_o,
    output logic sel_fall_o
);

    logic prev_q;
    logic rise_pend_q, rise_pend_d;
    logic fall_pend_q, fall_pend_d;
    logic overflow_q, overflow_d;
    logic rise_det, fall_det;

    assign rise_det = armed_i & en_i & rise_en_i &  d_i & ~prev_q;
    assign fall_det = armed_i & en_i & fall_en_i & ~d_i &  prev_q;

    // Pending bits: a new edge wins over a same-cycle grant; an edge hitting
    // an ungranted pending bit is lost and recorded as overflow.
    always_comb begin
        rise_pend_d = (rise_pend_q & ~grant_rise_i) | rise_det;
        fall_pend_d = (fall_pend_q & ~grant_fall_i) | fall_det;
        overflow_d  = overflow_q
                    | (rise_det & rise_pend_q & ~grant_rise_i)
                    | (fall_det & fall_pend_q & ~grant_fall_i);
    end

    // Line history plus pending/overflow state; clear keeps tracking the line.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q      <= 1'b0;
            rise_pend_q <= 1'b0;
            fall_pend_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (clr_i) begin
            prev_q      <= d_i;
            rise_pend_q <= 1'b0;
            fall_pend_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            prev_q      <= d_i;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            overflow_q  <= overflow_d;
        end
    end

    // With both edges pending, a line that is currently low last fell, so the
    // rise is older and goes first; a high line means the fall is older.
    assign sel_fall_o  = fall_pend_q & (~rise_pend_q | prev_q);
    assign rise_pend_o = rise_pend_q;
    assign fall_pend_o = fall_pend_q;
    assign overflow_o  = overflow_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: per-channel edge capture serialized
// round-robin onto a single valid/ready event stream.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter  int NumChan = 4,
    localparam int ChanW   = (NumChan > 1) ? $clog2(NumChan) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic [NumChan-1:0]   d_i,
    input  logic [NumChan-1:0]   en_i,
    input  logic [NumChan-1:0]   rise_en_i,
    input  logic [NumChan-1:0]   fall_en_i,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [ChanW-1:0]     evt_chan_o,
    output logic                 evt_fall_o,
    output logic [2*NumChan-1:0] pending_o,
    output logic [NumChan-1:0]   overflow_o
);

    arb_state_e         state_q, state_d;
    logic [ChanW-1:0]   ptr_q, ptr_d;
    logic [ChanW-1:0]   chan_q, chan_d;
    edge_e              fall_q, fall_d;
    logic               armed_q;

    logic [NumChan-1:0] rise_pend, fall_pend, pend_any, sel_fall;
    logic [NumChan-1:0] grant_rise, grant_fall;
    logic               sel_found;
    logic [ChanW-1:0]   sel_chan;
    int                 idx;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        edge_evt_chan u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .clr_i        (clr_i),
            .armed_i      (armed_q),
            .d_i          (d_i[c]),
            .en_i         (en_i[c]),
            .rise_en_i    (rise_en_i[c]),
            .fall_en_i    (fall_en_i[c]),
            .grant_rise_i (grant_rise[c]),
            .grant_fall_i (grant_fall[c]),
            .rise_pend_o  (rise_pend[c]),
            .fall_pend_o  (fall_pend[c]),
            .overflow_o   (overflow_o[c]),
            .sel_fall_o   (sel_fall[c])
        );
    end

    assign pend_any = rise_pend | fall_pend;

    // Round-robin pick: first channel with anything pending, from ptr upward.
    always_comb begin
        sel_found = 1'b0;
        sel_chan  = '0;
        idx       = 0;
        for (int i = 0; i < NumChan; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NumChan) idx = idx - NumChan;
            if (!sel_found && pend_any[idx[ChanW-1:0]]) begin
                sel_found = 1'b1;
                sel_chan  = idx[ChanW-1:0];
            end
        end
    end

    // Next state, output registers and grants; loads when idle or on handshake.
    // NOTE: every signal gets a default before the branches so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        chan_d     = chan_q;
        fall_d     = fall_q;
        grant_rise = '0;
        grant_fall = '0;
        if ((state_q == IDLE) || evt_ready_i) begin
            if (sel_found) begin
                state_d = HOLD;
                chan_d  = sel_chan;
                fall_d  = sel_fall[sel_chan] ? EDGE_FALL : EDGE_RISE;
                ptr_d   = (sel_chan == ChanW'(NumChan - 1)) ? '0 : sel_chan + 1'b1;
                if (sel_fall[sel_chan]) grant_fall[sel_chan] = 1'b1;
                else                    grant_rise[sel_chan] = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Arbiter registers; armed drops for one cycle after reset or clear.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            chan_q  <= '0;
            fall_q  <= EDGE_RISE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            chan_q  <= chan_d;
            fall_q  <= fall_d;
            armed_q <= 1'b1;
        end
    end

    assign evt_valid_o = (state_q == HOLD);
    assign evt_chan_o  = chan_q;
    assign evt_fall_o  = fall_q;
    assign pending_o   = {fall_pend, rise_pend};

endmodule
